// File: rtl/pc_stack_if.sv
// Bundle of the program-counter control strobes and the registered PC/stack status.
// Strobes are single-cycle requests sampled on the rising clock; there is no ready/back-pressure.
interface pc_stack_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] depth;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, load, inc, call, ret,
    input  out, depth, overflow, underflow
  );

  modport slave (
    input  in, load, inc, call, ret,
    output out, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_stack.sv
// Registered program counter with a LIFO return-address stack.
// Exactly one action per edge, priority load > call > ret > inc > hold.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic        clk,
  input logic        reset,
  pc_stack_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_CALL,
    ACT_RET,
    ACT_INC
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [CNT_W-1:0] depth_q, depth_n;
  logic             ovf_q, ovf_n;
  logic             unf_q, unf_n;
  logic             push;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic [WIDTH-1:0] stack [DEPTH];

  assign push_idx = IDX_W'(depth_q);
  assign top_idx  = IDX_W'(depth_q - CNT_W'(1));

  always_comb begin
    act = ACT_HOLD;
    if (bus.load)      act = ACT_LOAD;
    else if (bus.call) act = ACT_CALL;
    else if (bus.ret)  act = ACT_RET;
    else if (bus.inc)  act = ACT_INC;
  end

  always_comb begin
    pc_n    = pc_q;
    depth_n = depth_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    push    = 1'b0;
    case (act)
      ACT_LOAD: pc_n = bus.in;
      ACT_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        pc_n = bus.in;
        if (depth_q != FULL) begin
          push    = 1'b1;
          depth_n = depth_q + CNT_W'(1);
        end else begin
          ovf_n = 1'b1;
        end
      end
      ACT_RET: begin
        if (depth_q != '0) begin
          pc_n    = stack[top_idx];
          depth_n = depth_q - CNT_W'(1);
        end else begin
          unf_n = 1'b1;
        end
      end
      ACT_INC:  pc_n = pc_q + WIDTH'(1);
      default:  pc_n = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_n;
      depth_q <= depth_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  // Stack contents need no reset; depth alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) stack[push_idx] <= pc_q + WIDTH'(1);
  end

  assign bus.out       = pc_q;
  assign bus.depth     = depth_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
